fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning.
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, prefetch buffer entries (power of two, 2..8)

REQ-002 SHALL provide ports, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all state updates on rising edge
- reset, input, 1, synchronous, active-high
- imem_req, output, 1, read request this cycle
- imem_addr, output, 32, word-aligned read address
- imem_rdata, input, 32, read data, valid exactly 1 cycle after imem_req
- redirect_valid, input, 1, branch/jump redirect strobe
- redirect_pc, input, 32, redirect target
- out_valid, output, 1, buffer head holds an instruction
- out_ready, input, 1, downstream accepts the head
- pc_out, output, 32, PC of head instruction
- instruction, output, 32, head instruction word

REQ-003 SHALL use one clock and a synchronous, active-high reset named clk and reset.

Function
REQ-004 SHALL hold fetch_pc, a DEPTH-entry FIFO of {pc, instr}, an occupancy count (0..DEPTH), and a 1-bit inflight flag.
REQ-005 SHALL assert imem_req with imem_addr=fetch_pc when not in reset, redirect_valid=0, and count+inflight < DEPTH; fetch_pc += 4 (mod 2^32) on each request.
REQ-006 SHALL set inflight=1 the cycle after a request; the response is pushed into the FIFO at the end of that cycle with pc = the address requested.
REQ-007 SHALL not bypass: pushed entries are visible at outputs the following cycle; first-fetch latency from reset release is 2 cycles (req in cycle 0, push in cycle 1, out_valid in cycle 2).
REQ-008 SHALL assert out_valid iff count>0; pc_out/instruction SHALL show the head entry and stay stable while out_valid=1 and out_ready=0.
REQ-009 SHALL pop the head when out_valid and out_ready are both high; simultaneous push and pop SHALL leave count unchanged.
REQ-010 SHALL sustain one instruction per cycle in steady state when out_ready is held high.
REQ-011 On redirect_valid=1: clear FIFO (count=0), discard any in-flight response (no push), set fetch_pc = {redirect_pc[31:2], 2'b00}, issue no request that cycle; a concurrent out_valid&out_ready handshake is complete from the consumer's view.
REQ-012 SHALL issue the first post-redirect request the cycle after the redirect; back-to-back redirects SHALL each overwrite fetch_pc, the last one wins.
REQ-013 Full (count=DEPTH, or count+inflight=DEPTH) SHALL suppress imem_req; imem_rdata SHALL be ignored when no response is expected.
REQ-014 pc wraps from 32'hFFFF_FFFC to 32'h0000_0000 without error.

Reset
REQ-015 While reset=1: imem_req=0, imem_addr=RESET_PC, out_valid=0, pc_out=0, instruction=0, count=0, inflight=0, fetch_pc=RESET_PC; statistics counters=0.
REQ-016 Reset asserted mid-operation SHALL drop buffered and in-flight data; the response to a pre-reset request SHALL not be pushed.

Configuration
REQ-017 With FETCH_STATS_EN defined, SHALL add outputs stat_fetched (32, count of FIFO pushes) and stat_stall (32, count of cycles with reset=0 and out_valid=0), both saturating at 32'hFFFF_FFFF.
REQ-018 Without FETCH_STATS_EN, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-019 Reset release, out_ready=1, imem returns mem[a]=a^32'hA5A5_0000 -> out_valid in cycle 2, pc_out sequence 0,4,8,C... one per cycle.
REQ-020 out_ready=0 for 10 cycles -> count reaches 4, imem_req=0, head stays pc_out=0; then out_ready=1 -> pcs 0,4,8,C,10 with no gaps or duplicates.
REQ-021 redirect_valid=1 with redirect_pc=32'h0000_1003 while 3 entries are buffered -> out_valid=0 next cycle, imem_addr=32'h1000 the cycle after the redirect, first pc_out=32'h1000 two cycles later.
REQ-022 Reset pulse while inflight=1 and count=2 -> all outputs at reset values, refetch starts at RESET_PC, stale data never appears.
REQ-023 redirect_pc=32'hFFFF_FFF8, out_ready=1 -> pc_out FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-024 With FETCH_STATS_EN, run REQ-019 for 20 cycles after reset -> stat_stall=2, stat_fetched=19.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding imem requests feeding a DEPTH-entry {pc, instr} prefetch FIFO.
// Optional FETCH_STATS_EN macro adds saturating stat_fetched / stat_stall counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc_out,
  output logic [31:0] instruction
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_stall
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      fetch_pc_reg;
  logic [31:0]      inflight_pc_reg;
  logic             inflight_reg;
  logic [CNT_W-1:0] count_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  logic [CNT_W-1:0] occupancy;
  logic             push;
  logic             pop;
  logic             unused_redirect_bits;

  // A slot is reserved for the outstanding response, so the FIFO can never overflow.
  assign occupancy  = count_reg + CNT_W'(inflight_reg);
  assign imem_req   = !reset && !redirect_valid && (occupancy < DEPTH_C);
  assign imem_addr  = reset ? RESET_PC : fetch_pc_reg;
  assign out_valid  = !reset && (count_reg != '0);
  assign pop        = out_valid && out_ready;
  assign push       = inflight_reg && !redirect_valid && !reset;
  assign pc_out      = out_valid ? pc_mem[rd_ptr_reg]    : 32'h0;
  assign instruction = out_valid ? instr_mem[rd_ptr_reg] : 32'h0;
  assign unused_redirect_bits = &{1'b0, redirect_pc[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      inflight_pc_reg <= RESET_PC;
      inflight_reg    <= 1'b0;
      count_reg       <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
    end else if (redirect_valid) begin
      // Flush everything, including the response still on its way back.
      fetch_pc_reg <= {redirect_pc[31:2], 2'b00};
      inflight_reg <= 1'b0;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
    end else begin
      inflight_reg <= imem_req;
      if (imem_req) begin
        inflight_pc_reg <= fetch_pc_reg;
        fetch_pc_reg    <= fetch_pc_reg + 32'd4;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= inflight_pc_reg;
      instr_mem[wr_ptr_reg] <= imem_rdata;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetched <= 32'h0;
      stat_stall   <= 32'h0;
    end else begin
      if (push && (stat_fetched != 32'hFFFF_FFFF)) stat_fetched <= stat_fetched + 32'd1;
      if (!out_valid && (stat_stall != 32'hFFFF_FFFF)) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the stimulus keeps a queue of expected program-order PCs,
// a negedge monitor pops and compares on every out_valid&out_ready handshake.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] instruction;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_stall;
`endif

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .instruction(instruction)
`ifdef FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          handshakes = 0;
  logic [31:0] exp_q[$];
  logic [31:0] next_pc;
  logic        req_s;
  logic [31:0] addr_s;
  logic        cur_reset;
  logic        cur_rv;
  logic [31:0] cur_rpc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference stream: after reset/redirect the consumer sees target, target+4, ... (mod 2^32).
  task automatic restart(input logic [31:0] target);
    exp_q.delete();
    next_pc = target;
  endtask

  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_pc);
      next_pc = next_pc + 32'd4;
    end
  endtask

  // Apply inputs just after a rising edge, then move to the falling edge for sampling.
  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    reset = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    cur_reset = r; cur_rv = rv; cur_rpc = rpc;
    @(negedge clk);
    req_s = imem_req;
    addr_s = imem_addr;
  endtask

  // Memory answers one cycle after a request; garbage otherwise. Model flushes after the cycle's handshake.
  task automatic tick();
    @(posedge clk);
    #1;
    imem_rdata = req_s ? (addr_s ^ KEY) : $urandom();
    if (cur_reset) restart(RST_PC);
    else if (cur_rv) restart({cur_rpc[31:2], 2'b00});
    topup();
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      handshakes++;
      $display("xact pc=%h instr=%h", pc_out, instruction);
      if (exp_q.size() == 0) begin
        check("scoreboard_nonempty", 32'd0, 32'd1);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("pc_out", pc_out, e);
        check("instruction", instruction, e ^ KEY);
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    restart(RST_PC);
    topup();

    // Reset state
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 32'h0, 1);
      check("rst_imem_req", imem_req, 0);
      check("rst_imem_addr", imem_addr, RST_PC);
      check("rst_out_valid", out_valid, 0);
      check("rst_pc_out", pc_out, 0);
      check("rst_instruction", instruction, 0);
      tick();
    end

    // Streaming with out_ready held high
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 32'h0, 1);
      if (k == 0) begin
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, RST_PC);
      end
      if (k == 1) check("second_addr", imem_addr, RST_PC + 32'd4);
      if (k < 2) check("latency_out_valid", out_valid, 0);
      else check("throughput_out_valid", out_valid, 1);
      if (k == 2) check("first_pc_out", pc_out, RST_PC);
      tick();
    end
    drive(0, 0, 32'h0, 1);
`ifdef FETCH_STATS_EN
    check("stat_stall", stat_stall, 32'd2);
    check("stat_fetched", stat_fetched, 32'd19);
`endif
    tick();

    // Back-pressure: fill the buffer, head must hold, then drain without gaps
    drive(1, 0, 32'h0, 0); tick();
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 32'h0, 0);
      if (k >= 2) check("head_stable", pc_out, RST_PC);
      if (k == 9) begin
        check("full_no_req", imem_req, 0);
        check("full_out_valid", out_valid, 1);
      end
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 32'h0, 1);
      check("drain_no_gap", out_valid, 1);
      tick();
    end

    // Redirect with 3 entries buffered
    drive(1, 0, 32'h0, 0); tick();
    for (int k = 0; k < 4; k++) begin drive(0, 0, 32'h0, 0); tick(); end
    drive(0, 1, 32'h0000_1003, 0);
    check("redir_cycle_head", pc_out, RST_PC);
    check("redir_cycle_no_req", imem_req, 0);
    tick();
    drive(0, 0, 32'h0, 0);
    check("redir_flushed", out_valid, 0);
    check("redir_req", imem_req, 1);
    check("redir_addr", imem_addr, 32'h0000_1000);
    tick();
    drive(0, 0, 32'h0, 0);
    check("redir_wait", out_valid, 0);
    tick();
    drive(0, 0, 32'h0, 1);
    check("redir_out_valid", out_valid, 1);
    check("redir_pc_out", pc_out, 32'h0000_1000);
    tick();

    // Reset while inflight=1, count=2
    drive(1, 0, 32'h0, 0); tick();
    for (int k = 0; k < 3; k++) begin drive(0, 0, 32'h0, 0); tick(); end
    drive(1, 0, 32'h0, 0);
    check("midrst_req", imem_req, 0);
    check("midrst_addr", imem_addr, RST_PC);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_pc_out", pc_out, 0);
    check("midrst_instruction", instruction, 0);
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 32'h0, 1);
      if (k == 0) check("refetch_addr", imem_addr, RST_PC);
      if (k < 2) check("refetch_latency", out_valid, 0);
      if (k == 2) check("refetch_pc_out", pc_out, RST_PC);
      tick();
    end

    // Wrap-around
    drive(0, 1, 32'hFFFF_FFF8, 1); tick();
    for (int k = 1; k < 6; k++) begin
      drive(0, 0, 32'h0, 1);
      if (k == 3) check("wrap_pc0", pc_out, 32'hFFFF_FFF8);
      if (k == 4) check("wrap_pc1", pc_out, 32'hFFFF_FFFC);
      if (k == 5) check("wrap_pc2", pc_out, 32'h0000_0000);
      tick();
    end

    // Back-to-back redirects: the last one wins
    drive(0, 1, 32'h0000_2000, 1); tick();
    drive(0, 1, 32'h0000_3006, 1);
    check("b2b_no_req", imem_req, 0);
    tick();
    drive(0, 0, 32'h0, 1);
    check("b2b_req", imem_req, 1);
    check("b2b_addr", imem_addr, 32'h0000_3004);
    tick();

    // Randomized traffic checked by the scoreboard
    for (int k = 0; k < 400; k++) begin
      logic r, rv, rdy;
      r = ($urandom_range(0, 99) == 0);
      rv = !r && ($urandom_range(0, 99) < 4);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
      rdy = ($urandom_range(0, 9) < 7);
      drive(r, rv, tgt, rdy);
      tick();
    end
    check("handshakes_seen", 32'(handshakes >= 150), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
